// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port 32-bit memory between the RV32I core's instruction
// fetch (IF) and load/store (LS) requesters. Only one memory transaction is
// outstanding at a time. LS normally wins arbitration, but after MAX_STREAK
// consecutive LS grants while IF is waiting, IF is granted once. If the memory
// does not answer within TIMEOUT cycles, the owner gets an error response.
//
// Parameters
//   AW          address width (byte address)
//   MAX_STREAK  consecutive LS grants allowed while IF waits (>= 1)
//   TIMEOUT     WAIT cycles without i_mem_rvalid before error return (>= 1)
//
// Ports
//   i_clk, i_rst          clock (rising edge), synchronous active-low reset
//   i_if_req/i_if_addr    IF read request, held with address until o_if_gnt
//   o_if_gnt              1-cycle pulse: IF request accepted
//   o_if_rvalid/rdata/err IF response pulse, read data, timeout flag
//   i_ls_req/we/be/addr/wdata  LS request, held with fields until o_ls_gnt
//   o_ls_gnt              1-cycle pulse: LS request accepted
//   o_ls_rvalid/rdata/err LS response pulse, read data (0 on writes), timeout
//   o_mem_req             1-cycle memory command strobe
//   o_mem_we/be/addr/wdata  command fields, stable while o_mem_req is high
//   i_mem_rvalid/rdata    memory response strobe (reads and writes) and data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // instruction fetch port
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [31:0]   o_if_rdata,
  output logic          o_if_err,
  // load/store port
  input  logic          i_ls_req,
  input  logic          i_ls_we,
  input  logic [3:0]    i_ls_be,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [31:0]   i_ls_wdata,
  output logic          o_ls_gnt,
  output logic          o_ls_rvalid,
  output logic [31:0]   o_ls_rdata,
  output logic          o_ls_err,
  // memory port
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [3:0]    o_mem_be,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic          i_mem_rvalid,
  input  logic [31:0]   i_mem_rdata
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            ls_wr_q, ls_wr_d;       // current LS transaction is a write
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            if_gnt_q, if_gnt_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic            if_err_q, if_err_d;

  logic            ls_gnt_q, ls_gnt_d;
  logic            ls_rvalid_q, ls_rvalid_d;
  logic [31:0]     ls_rdata_q, ls_rdata_d;
  logic            ls_err_q, ls_err_d;

  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  // ---------------------------------------------------------------------------
  // Arbitration terms
  // ---------------------------------------------------------------------------
  logic if_req_eff;
  logic ls_req_eff;
  logic rsp_hit;
  logic tmo_hit;
  logic slot_free;
  logic if_wins;
  logic grant_if;
  logic grant_ls;

  // A requester keeps its request up during the cycle its grant pulse is
  // visible. With a zero-latency memory the slot frees in that same cycle, so
  // the already-accepted request must not be seen as pending again.
  assign if_req_eff = i_if_req & ~if_gnt_q;
  assign ls_req_eff = i_ls_req & ~ls_gnt_q;

  assign rsp_hit   = (state_q == ST_WAIT) & i_mem_rvalid;
  assign tmo_hit   = (state_q == ST_WAIT) & ~i_mem_rvalid & (tmo_q == TMO_LAST);
  assign slot_free = (state_q == ST_IDLE) | rsp_hit;

  // LS has priority unless IF has already waited through MAX_STREAK LS grants.
  assign if_wins  = if_req_eff & (~ls_req_eff | (streak_q == STREAK_MAX));
  assign grant_if = slot_free & if_wins;
  assign grant_ls = slot_free & ls_req_eff & ~if_wins;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    ls_wr_d     = ls_wr_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;

    if_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = '0;
    if_err_d    = 1'b0;

    ls_gnt_d    = 1'b0;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = '0;
    ls_err_d    = 1'b0;

    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // Completion of the outstanding transaction: memory answer or timeout.
    if (rsp_hit) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      if (owner_q == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = i_mem_rdata;
      end else begin
        ls_rvalid_d = 1'b1;
        ls_rdata_d  = ls_wr_q ? 32'h0 : i_mem_rdata;
      end
    end else if (tmo_hit) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      if (owner_q == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_err_d    = 1'b1;
      end else begin
        ls_rvalid_d = 1'b1;
        ls_err_d    = 1'b1;
      end
    end else if (state_q == ST_WAIT) begin
      tmo_d = tmo_q + TW'(1);
    end

    // New grant; on a response edge this overrides the return to IDLE so the
    // next transaction starts without a bubble.
    if (grant_if) begin
      state_d     = ST_WAIT;
      owner_d     = OWN_IF;
      ls_wr_d     = 1'b0;
      tmo_d       = '0;
      streak_d    = '0;
      if_gnt_d    = 1'b1;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_be_d    = 4'hF;
      mem_addr_d  = i_if_addr;
      mem_wdata_d = 32'h0;
    end else if (grant_ls) begin
      state_d     = ST_WAIT;
      owner_d     = OWN_LS;
      ls_wr_d     = i_ls_we;
      tmo_d       = '0;
      ls_gnt_d    = 1'b1;
      mem_req_d   = 1'b1;
      mem_we_d    = i_ls_we;
      mem_be_d    = i_ls_be;
      mem_addr_d  = i_ls_addr;
      mem_wdata_d = i_ls_wdata;
      // if_wins is forced at STREAK_MAX, so this increment cannot overflow.
      streak_d    = if_req_eff ? streak_q + SW'(1) : '0;
    end else if (!if_req_eff) begin
      streak_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      ls_wr_q     <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ls_wr_q     <= ls_wr_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      ls_gnt_q    <= ls_gnt_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_if_gnt    = if_gnt_q;
  assign o_if_rvalid = if_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_if_err    = if_err_q;
  assign o_ls_gnt    = ls_gnt_q;
  assign o_ls_rvalid = ls_rvalid_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_ls_err    = ls_err_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Stimulus pushes the expected grants and
// responses (hand-derived) into two queues; a monitor on the falling edge pops
// and compares whenever the DUT shows a grant/command or a response. Requester
// and memory behaviour are modelled by small independent processes.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid, o_if_err;
  logic [31:0] o_if_rdata;
  logic        i_ls_req, i_ls_we;
  logic [3:0]  i_ls_be;
  logic [31:0] i_ls_addr, i_ls_wdata;
  logic        o_ls_gnt, o_ls_rvalid, o_ls_err;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req, o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .o_if_rdata  (o_if_rdata),
    .o_if_err    (o_if_err),
    .i_ls_req    (i_ls_req),
    .i_ls_we     (i_ls_we),
    .i_ls_be     (i_ls_be),
    .i_ls_addr   (i_ls_addr),
    .i_ls_wdata  (i_ls_wdata),
    .o_ls_gnt    (o_ls_gnt),
    .o_ls_rvalid (o_ls_rvalid),
    .o_ls_rdata  (o_ls_rdata),
    .o_ls_err    (o_ls_err),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_be    (o_mem_be),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata (i_mem_rdata)
  );

  typedef struct packed {
    logic        is_ls;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic        is_ls;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ls_cmd_t;

  gnt_t        exp_g[$];
  rsp_t        exp_r[$];
  logic [31:0] if_pend[$];
  ls_cmd_t     ls_pend[$];
  logic [31:0] mem_img [logic [31:0]];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int if_req_cyc, if_gnt_cyc, if_rv_cyc, ls_gnt_cyc, ls_rv_cyc;
  int n_rv_seen = 0;

  // memory model controls: latency in cycles after the command, -1 = silent
  int          mem_lat  = 1;
  bit          force_rv = 1'b0;
  bit          m_pend;
  int          m_cnt;
  logic [31:0] m_addr;
  logic        m_we;

  gnt_t mg;
  rsp_t mr;

  task automatic check(input string name, input logic [191:0] got,
                       input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [191:0] outs_all();
    return 192'({o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
                 o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
                 o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata});
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle counter, requesters, memory
  // ---------------------------------------------------------------------------
  initial forever begin
    @(posedge i_clk);
    cyc = cyc + 1;
  end

  initial begin
    i_if_req  = 1'b0;
    i_if_addr = '0;
    forever begin
      @(posedge i_clk); #1;
      if (o_if_gnt && if_pend.size() > 0) void'(if_pend.pop_front());
      if (if_pend.size() > 0) begin
        if (!i_if_req) if_req_cyc = cyc;
        i_if_req  = 1'b1;
        i_if_addr = if_pend[0];
      end else begin
        i_if_req  = 1'b0;
        i_if_addr = '0;
      end
    end
  end

  initial begin
    i_ls_req   = 1'b0;
    i_ls_we    = 1'b0;
    i_ls_be    = '0;
    i_ls_addr  = '0;
    i_ls_wdata = '0;
    forever begin
      @(posedge i_clk); #1;
      if (o_ls_gnt && ls_pend.size() > 0) void'(ls_pend.pop_front());
      if (ls_pend.size() > 0) begin
        i_ls_req   = 1'b1;
        i_ls_we    = ls_pend[0].we;
        i_ls_be    = ls_pend[0].be;
        i_ls_addr  = ls_pend[0].addr;
        i_ls_wdata = ls_pend[0].wdata;
      end else begin
        i_ls_req   = 1'b0;
        i_ls_we    = 1'b0;
        i_ls_be    = '0;
        i_ls_addr  = '0;
        i_ls_wdata = '0;
      end
    end
  end

  // Writes answer with garbage data so the arbiter's zeroing is observable.
  initial begin
    m_pend       = 1'b0;
    m_cnt        = 0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    forever begin
      @(posedge i_clk); #1;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
      if (o_mem_req) begin
        m_pend = (mem_lat >= 0);
        m_cnt  = mem_lat;
        m_addr = o_mem_addr;
        m_we   = o_mem_we;
      end
      if (force_rv) begin
        force_rv     = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hBAD0_BAD0;
      end else if (m_pend) begin
        if (m_cnt == 0) begin
          m_pend       = 1'b0;
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = m_we ? 32'hA5A5_A5A5 :
                         (mem_img.exists(m_addr) ? mem_img[m_addr] : 32'h0);
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial forever begin
    @(negedge i_clk);
    if (o_if_gnt || o_ls_gnt || o_mem_req) begin
      if (o_if_gnt) if_gnt_cyc = cyc;
      if (o_ls_gnt) ls_gnt_cyc = cyc;
      if (exp_g.size() == 0) begin
        check("unexpected_gnt", 192'({o_ls_gnt, o_if_gnt, o_mem_req}), 192'(0));
      end else begin
        mg = exp_g.pop_front();
        check("gnt", 192'({o_ls_gnt, o_if_gnt, o_mem_req, o_mem_we, o_mem_be,
                           o_mem_addr, o_mem_wdata}),
                     192'({mg.is_ls, ~mg.is_ls, 1'b1, mg.we, mg.be,
                           mg.addr, mg.wdata}));
      end
    end
    if (o_if_rvalid || o_ls_rvalid) begin
      n_rv_seen++;
      if (o_if_rvalid) if_rv_cyc = cyc;
      if (o_ls_rvalid) ls_rv_cyc = cyc;
      if (exp_r.size() == 0) begin
        check("unexpected_rvalid", 192'({o_ls_rvalid, o_if_rvalid}), 192'(0));
      end else begin
        mr = exp_r.pop_front();
        check("rsp", 192'({o_ls_rvalid, o_if_rvalid,
                           o_ls_rvalid ? o_ls_err : o_if_err,
                           o_ls_rvalid ? o_ls_rdata : o_if_rdata}),
                     192'({mr.is_ls, ~mr.is_ls, mr.err, mr.rdata}));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic exp_gnt(input logic is_ls, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    exp_g.push_back('{is_ls: is_ls, we: we, be: be, addr: addr, wdata: wdata});
  endtask

  task automatic exp_rsp(input logic is_ls, input logic err,
                         input logic [31:0] rdata);
    exp_r.push_back('{is_ls: is_ls, err: err, rdata: rdata});
  endtask

  task automatic push_ls(input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    ls_pend.push_back('{we: we, be: be, addr: addr, wdata: wdata});
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_g.size() + exp_r.size() + if_pend.size() + ls_pend.size()) != 0
           && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    repeat (3) @(negedge i_clk);
    check(name, 192'(exp_g.size() + exp_r.size() + if_pend.size() + ls_pend.size()),
          192'(0));
    exp_g.delete();
    exp_r.delete();
    if_pend.delete();
    ls_pend.delete();
  endtask

  task automatic wait_if_gnt(input string name);
    int n = 0;
    while (!o_if_gnt && n < 30) begin
      @(negedge i_clk);
      n++;
    end
    check(name, 192'(o_if_gnt), 192'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int rv_before;
    i_rst = 1'b0;

    mem_img[32'h100] = 32'h0000_0013;
    mem_img[32'h104] = 32'h0050_0093;
    for (int i = 0; i < 12; i++) mem_img[32'h300 + 32'(4 * i)] = 32'h1000 + 32'(i);
    for (int j = 0; j < 3; j++)  mem_img[32'h400 + 32'(4 * j)] = 32'h2000 + 32'(j);
    mem_img[32'h500] = 32'h0000_0055;
    mem_img[32'h504] = 32'h0000_0077;
    mem_img[32'h600] = 32'h0000_0011;
    mem_img[32'h604] = 32'h00A0_0113;
    mem_img[32'h608] = 32'h00B0_0193;
    mem_img[32'h700] = 32'hCAFE_F00D;

    // reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_outputs", outs_all(), 192'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);

    // IF only, 2-cycle memory
    mem_lat = 2;
    exp_gnt(1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
    exp_rsp(1'b0, 1'b0, 32'h0000_0013);
    if_pend.push_back(32'h100);
    drain("if_only_drain", 40);
    check("if_gnt_latency", 192'(if_gnt_cyc - if_req_cyc), 192'(1));
    check("if_rsp_latency", 192'(if_rv_cyc - if_gnt_cyc), 192'(3));

    // IF + LS write in the same cycle: LS first, write ack has zero data
    mem_lat = 1;
    exp_gnt(1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
    exp_gnt(1'b0, 1'b0, 4'hF, 32'h104, 32'h0);
    exp_rsp(1'b1, 1'b0, 32'h0);
    exp_rsp(1'b0, 1'b0, 32'h0050_0093);
    push_ls(1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
    if_pend.push_back(32'h104);
    drain("collide_drain", 40);

    // both held: LS x4 then IF, three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        exp_gnt(1'b1, 1'b0, 4'hF, 32'h300 + 32'(16 * r + 4 * i), 32'h0);
        exp_rsp(1'b1, 1'b0, 32'h1000 + 32'(4 * r + i));
        push_ls(1'b0, 4'hF, 32'h300 + 32'(16 * r + 4 * i), 32'h0);
      end
      exp_gnt(1'b0, 1'b0, 4'hF, 32'h400 + 32'(4 * r), 32'h0);
      exp_rsp(1'b0, 1'b0, 32'h2000 + 32'(r));
      if_pend.push_back(32'h400 + 32'(4 * r));
    end
    drain("streak_drain", 200);

    // silent memory: timeout after 16 WAIT cycles, late strobe ignored
    mem_lat = -1;
    exp_gnt(1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
    exp_rsp(1'b1, 1'b1, 32'h0);
    push_ls(1'b0, 4'hF, 32'h500, 32'h0);
    drain("timeout_drain", 60);
    check("timeout_cycles", 192'(ls_rv_cyc - ls_gnt_cyc), 192'(16));
    rv_before = n_rv_seen;
    force_rv  = 1'b1;
    repeat (5) @(negedge i_clk);
    check("late_rvalid_ignored", 192'(n_rv_seen - rv_before), 192'(0));
    mem_lat = 2;
    exp_gnt(1'b1, 1'b0, 4'hF, 32'h504, 32'h0);
    exp_rsp(1'b1, 1'b0, 32'h0000_0077);
    push_ls(1'b0, 4'hF, 32'h504, 32'h0);
    drain("after_timeout_drain", 40);

    // reset one cycle into WAIT abandons the transaction
    mem_lat = 3;
    exp_gnt(1'b0, 1'b0, 4'hF, 32'h600, 32'h0);
    if_pend.push_back(32'h600);
    wait_if_gnt("reset_wait_gnt");
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("reset_mid_wait_outputs", outs_all(), 192'(0));
    rv_before = n_rv_seen;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    repeat (6) @(negedge i_clk);
    check("abandoned_rsp_dropped", 192'(n_rv_seen - rv_before), 192'(0));
    mem_lat = 2;
    exp_gnt(1'b0, 1'b0, 4'hF, 32'h604, 32'h0);
    exp_rsp(1'b0, 1'b0, 32'h00A0_0113);
    if_pend.push_back(32'h604);
    drain("after_reset_drain", 40);

    // back-to-back: LS grant in the same cycle as the IF response
    mem_lat = 3;
    exp_gnt(1'b0, 1'b0, 4'hF, 32'h608, 32'h0);
    exp_gnt(1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
    exp_rsp(1'b0, 1'b0, 32'h00B0_0193);
    exp_rsp(1'b1, 1'b0, 32'hCAFE_F00D);
    if_pend.push_back(32'h608);
    wait_if_gnt("b2b_wait_gnt");
    push_ls(1'b0, 4'hF, 32'h700, 32'h0);
    drain("b2b_drain", 40);
    check("b2b_if_rsp_cycle", 192'(if_rv_cyc - if_gnt_cyc), 192'(4));
    check("b2b_ls_gnt_cycle", 192'(ls_gnt_cyc - if_gnt_cyc), 192'(4));

    // zero-latency memory
    mem_lat = 0;
    exp_gnt(1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
    exp_rsp(1'b0, 1'b0, 32'h0000_0013);
    if_pend.push_back(32'h100);
    drain("zero_lat_if_drain", 40);
    check("zero_lat_if_cycle", 192'(if_rv_cyc - if_gnt_cyc), 192'(1));
    exp_gnt(1'b1, 1'b1, 4'b1100, 32'h204, 32'h1234_5678);
    exp_rsp(1'b1, 1'b0, 32'h0);
    push_ls(1'b1, 4'b1100, 32'h204, 32'h1234_5678);
    drain("zero_lat_ls_drain", 40);
    check("zero_lat_ls_cycle", 192'(ls_rv_cyc - ls_gnt_cyc), 192'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
